// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial-link dequeue path.
package serial_link_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      OFFER = 2'd1,
      FEED  = 2'd2,
      FLUSH = 2'd3
   } feed_state_e;

   typedef logic [15:0] cnt16_t;

   localparam cnt16_t CntMax = 16'hFFFF;

   function automatic cnt16_t sat_inc(input cnt16_t value);
      return (value == CntMax) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/dequeue_frame_collector.sv
// Frame buffer for the dequeue path: blocks land in consecutive slots, block 0
// in the LSBs; the slot index wraps after the last slot.
module dequeue_frame_collector #(
   parameter int BlockSize = 8,
   parameter int NumBlocks = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           wr_en,
   input  logic [BlockSize-1:0]           blk,
   output logic [BlockSize*NumBlocks-1:0] frame,
   output logic                           last
);
   localparam int IdxW = (NumBlocks > 1) ? $clog2(NumBlocks) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBlocks - 1);

   logic [IdxW-1:0] blk_idx_reg;

   assign last = (blk_idx_reg == LastIdx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_idx_reg <= '0;
      end else if (flush) begin
         blk_idx_reg <= '0;
      end else if (wr_en) begin
         blk_idx_reg <= last ? '0 : blk_idx_reg + IdxW'(1);
      end
   end

   for (genvar gi = 0; gi < NumBlocks; gi++) begin : gen_slot
      logic [BlockSize-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_reg <= '0;
         end else if (flush) begin
            slot_reg <= '0;
         end else if (wr_en && (blk_idx_reg == IdxW'(gi))) begin
            slot_reg <= blk;
         end
      end

      assign frame[gi*BlockSize +: BlockSize] = slot_reg;
   end

endmodule

// File: rtl/dequeue_feed_ctrl.sv
// Dequeue feed controller: assembles a frame, offers it to the shift register,
// then streams filler blocks while guarding against a missing first handshake.
module dequeue_feed_ctrl
   import serial_link_pkg::*;
#(
   parameter int BlockSize     = 8,
   parameter int NumBlocks     = 4,
   parameter int TimeoutCycles = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clr_i,
   input  logic                           enable_i,
   input  logic                           blk_valid_i,
   output logic                           blk_ready_o,
   input  logic [BlockSize-1:0]           blk_i,
   output logic                           sr_valid_o,
   input  logic                           sr_ready_i,
   output logic [BlockSize*NumBlocks-1:0] sr_data_o,
   output logic [BlockSize-1:0]           sr_new_packet_o,
   output logic                           sr_shift_en_o,
   input  logic                           sr_shift_en_i,
   input  logic                           sr_first_hs_i,
   output logic                           sr_clr_o,
   output logic                           timeout_o,
   output logic [15:0]                    frame_cnt_o,
   output logic [15:0]                    drop_cnt_o
);
   localparam int TimerW = $clog2(TimeoutCycles + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

   feed_state_e       state_reg, state_next;
   logic [TimerW-1:0] timer_reg;
   logic              flush_timeout_reg;
   cnt16_t            frame_cnt_reg, drop_cnt_reg;

   logic blk_last, fill_accept, offer_hs, timer_expired, timeout_flush;

   // clr_i wins over everything, so a block taken in that cycle is never stored.
   assign fill_accept   = (state_reg == FILL) && enable_i && blk_valid_i && !clr_i;
   assign offer_hs      = (state_reg == OFFER) && sr_ready_i && !clr_i;
   assign timer_expired = (state_reg == FEED) && (timer_reg == TimerLast) && !sr_first_hs_i;
   assign timeout_flush = timer_expired && !sr_ready_i && !clr_i;

   dequeue_frame_collector #(
      .BlockSize(BlockSize),
      .NumBlocks(NumBlocks)
   ) u_collector (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .flush(state_reg == FLUSH),
      .wr_en(fill_accept),
      .blk  (blk_i),
      .frame(sr_data_o),
      .last (blk_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= FILL;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clr_i) begin
         state_next = FLUSH;
      end else begin
         case (state_reg)
            FILL:    if (fill_accept && blk_last) state_next = OFFER;
            OFFER:   if (sr_ready_i) state_next = FEED;
            FEED: begin
               if (sr_ready_i) begin
                  state_next = FILL;
               end else if (timer_expired) begin
                  state_next = FLUSH;
               end
            end
            FLUSH:   state_next = FILL;
            default: state_next = FILL;
         endcase
      end
   end

   always_comb begin
      blk_ready_o   = 1'b0;
      sr_valid_o    = 1'b0;
      sr_shift_en_o = 1'b0;
      sr_clr_o      = 1'b0;
      timeout_o     = 1'b0;
      case (state_reg)
         FILL:  blk_ready_o = enable_i;
         OFFER: sr_valid_o  = 1'b1;
         FEED: begin
            sr_shift_en_o = enable_i && blk_valid_i;
            blk_ready_o   = sr_shift_en_i;
         end
         FLUSH: begin
            sr_clr_o  = 1'b1;
            timeout_o = flush_timeout_reg;
         end
         default: blk_ready_o = 1'b0;
      endcase
   end

   // The timer runs regardless of enable_i; leaving FEED restarts it from zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_reg         <= '0;
         flush_timeout_reg <= 1'b0;
         frame_cnt_reg     <= '0;
         drop_cnt_reg      <= '0;
      end else begin
         timer_reg         <= ((state_reg != FEED) || sr_first_hs_i) ? '0 : timer_reg + TimerW'(1);
         flush_timeout_reg <= timeout_flush;
         if (offer_hs) begin
            frame_cnt_reg <= sat_inc(frame_cnt_reg);
         end
         if (timeout_flush) begin
            drop_cnt_reg <= sat_inc(drop_cnt_reg);
         end
      end
   end

   assign sr_new_packet_o = blk_i;
   assign frame_cnt_o     = frame_cnt_reg;
   assign drop_cnt_o      = drop_cnt_reg;

endmodule

// File: tb/tb_dequeue_feed_ctrl.sv
// Self-checking bench for dequeue_feed_ctrl: directed scenarios plus random
// traffic, all compared every cycle against a behavioural frame model.
module tb_dequeue_feed_ctrl;
   localparam int BS = 8;
   localparam int NB = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_ni = 1'b0;
   logic          clr_i, enable_i, blk_valid_i, sr_ready_i, sr_shift_en_i, sr_first_hs_i;
   logic [BS-1:0] blk_i;
   logic          blk_ready_o, sr_valid_o, sr_shift_en_o, sr_clr_o, timeout_o;
   logic [BS*NB-1:0] sr_data_o;
   logic [BS-1:0] sr_new_packet_o;
   logic [15:0]   frame_cnt_o, drop_cnt_o;

   dequeue_feed_ctrl #(
      .BlockSize(BS),
      .NumBlocks(NB),
      .TimeoutCycles(TO)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .clr_i          (clr_i),
      .enable_i       (enable_i),
      .blk_valid_i    (blk_valid_i),
      .blk_ready_o    (blk_ready_o),
      .blk_i          (blk_i),
      .sr_valid_o     (sr_valid_o),
      .sr_ready_i     (sr_ready_i),
      .sr_data_o      (sr_data_o),
      .sr_new_packet_o(sr_new_packet_o),
      .sr_shift_en_o  (sr_shift_en_o),
      .sr_shift_en_i  (sr_shift_en_i),
      .sr_first_hs_i  (sr_first_hs_i),
      .sr_clr_o       (sr_clr_o),
      .timeout_o      (timeout_o),
      .frame_cnt_o    (frame_cnt_o),
      .drop_cnt_o     (drop_cnt_o)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model phases: 0 collecting, 1 presenting, 2 streaming, 3 purging.
   int            m_phase = 0;
   logic [BS-1:0] m_slot [NB];
   int            m_fill = 0, m_age = 0, m_frames = 0, m_drops = 0;
   bit            m_purge_to = 1'b0;
   int            sat_req = 0, sat_seen = 0;

   initial forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
         m_phase = 0; m_fill = 0; m_age = 0; m_frames = 0; m_drops = 0; m_purge_to = 1'b0;
         for (int i = 0; i < NB; i++) m_slot[i] = '0;
      end else begin
         if (sat_req != sat_seen) begin
            m_frames = 65535;
            sat_seen = sat_req;
         end
         if (m_phase == 3) begin
            m_fill = 0;
            for (int i = 0; i < NB; i++) m_slot[i] = '0;
         end
         if (clr_i) begin
            m_phase    = 3;
            m_purge_to = 1'b0;
         end else begin
            case (m_phase)
               0: if (enable_i && blk_valid_i) begin
                     m_slot[m_fill] = blk_i;
                     m_fill++;
                     if (m_fill == NB) begin
                        m_fill  = 0;
                        m_phase = 1;
                     end
                  end
               1: if (sr_ready_i) begin
                     if (m_frames < 65535) m_frames++;
                     m_phase = 2;
                     m_age   = 0;
                     $display("frame accepted data=%h count=%0d", sr_data_o, m_frames);
                  end
               2: if (sr_ready_i) begin
                     m_phase = 0;
                  end else if (sr_first_hs_i) begin
                     m_age = 0;
                  end else if (m_age == TO - 1) begin
                     m_phase    = 3;
                     m_purge_to = 1'b1;
                     if (m_drops < 65535) m_drops++;
                  end else begin
                     m_age++;
                  end
               default: m_phase = 0;
            endcase
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         logic e_ready, e_shift;
         e_ready = (m_phase == 0) ? enable_i : (m_phase == 2) ? sr_shift_en_i : 1'b0;
         e_shift = (m_phase == 2) && enable_i && blk_valid_i;
         chk("blk_ready_o", blk_ready_o, e_ready);
         chk("sr_valid_o", sr_valid_o, m_phase == 1);
         chk("sr_shift_en_o", sr_shift_en_o, e_shift);
         chk("sr_clr_o", sr_clr_o, m_phase == 3);
         chk("timeout_o", timeout_o, (m_phase == 3) && m_purge_to);
         chk("frame_cnt_o", frame_cnt_o, m_frames);
         chk("drop_cnt_o", drop_cnt_o, m_drops);
         if (m_phase == 1) chk("sr_data_o", sr_data_o, {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
         if (e_shift) chk("sr_new_packet_o", sr_new_packet_o, blk_i);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input logic [BS*NB-1:0] f);
      for (int i = 0; i < NB; i++) begin
         tick();
         enable_i    = 1'b1;
         blk_valid_i = 1'b1;
         blk_i       = f[i*BS +: BS];
      end
      tick();
      blk_valid_i = 1'b0;
   endtask

   task automatic ready_pulse();
      sr_ready_i = 1'b1;
      tick();
      sr_ready_i = 1'b0;
   endtask

   initial begin
      int n;
      int consumed;
      clr_i = 0; enable_i = 0; blk_valid_i = 0; blk_i = '0;
      sr_ready_i = 0; sr_shift_en_i = 0; sr_first_hs_i = 0;
      repeat (2) @(posedge clk);
      #1 enable_i = 1'b1;
      #1;
      chk("reset_blk_ready", blk_ready_o, 1);
      chk("reset_frame_cnt", frame_cnt_o, 0);
      chk("reset_drop_cnt", drop_cnt_o, 0);
      chk("reset_sr_valid", sr_valid_o, 0);
      chk("reset_sr_clr", sr_clr_o, 0);
      rst_ni = 1'b1;
      chk_on = 1'b1;

      // Basic frame assembly and a held offer
      load_frame(32'h07050301);
      #1;
      chk("req22_valid", sr_valid_o, 1);
      chk("req22_data", sr_data_o, 32'h07050301);
      tick(); tick(); #1;
      chk("req22_hold_valid", sr_valid_o, 1);
      chk("req22_hold_data", sr_data_o, 32'h07050301);
      ready_pulse(); #1;
      chk("req22_frame_cnt", frame_cnt_o, 1);

      // Three shifted blocks in FEED
      consumed = 0;
      for (int i = 0; i < 3; i++) begin
         blk_valid_i = 1'b1; sr_shift_en_i = 1'b1; blk_i = 8'($urandom);
         sr_first_hs_i = (i == 0);
         #1;
         chk("req23_blk_ready", blk_ready_o, 1);
         chk("req23_shift_en", sr_shift_en_o, 1);
         if (blk_ready_o && blk_valid_i) consumed++;
         tick();
      end
      blk_valid_i = 0; sr_shift_en_i = 0; sr_first_hs_i = 0;
      chk("req23_consumed", consumed, 3);
      ready_pulse(); #1;
      chk("req23_back_to_fill", blk_ready_o, 1);

      // Timeout with no first handshake
      load_frame(32'h44332211);
      ready_pulse();
      n = 0;
      #1;
      while (!sr_clr_o && n < 20) begin
         n++;
         tick(); #1;
      end
      chk("req24_feed_cycles", n, 8);
      chk("req24_timeout", timeout_o, 1);
      chk("req24_drop_cnt", drop_cnt_o, 1);
      tick(); #1;
      chk("req24_clr_len", sr_clr_o, 0);
      chk("req24_pulse_len", timeout_o, 0);

      // Frame consumed in the very cycle the timer expires
      load_frame(32'h88776655);
      ready_pulse();
      repeat (7) tick();
      ready_pulse(); #1;
      chk("req26_no_clr", sr_clr_o, 0);
      chk("req26_no_timeout", timeout_o, 0);
      chk("req26_in_fill", blk_ready_o, 1);
      chk("req26_drop_cnt", drop_cnt_o, 1);

      // Flush with a partial frame, then a fresh frame
      tick(); blk_valid_i = 1; blk_i = 8'h11;
      tick(); blk_i = 8'h22;
      tick(); blk_i = 8'h33; clr_i = 1;
      tick(); clr_i = 0; blk_valid_i = 0; #1;
      chk("req25_clr", sr_clr_o, 1);
      chk("req25_no_timeout", timeout_o, 0);
      chk("req25_no_ready", blk_ready_o, 0);
      tick(); #1;
      chk("req25_clr_len", sr_clr_o, 0);
      load_frame(32'hDDCCBBAA); #1;
      chk("req25_fresh_data", sr_data_o, 32'hDDCCBBAA);
      ready_pulse();
      ready_pulse();

      // Reset in the middle of a frame
      tick(); blk_valid_i = 1; blk_i = 8'h5A;
      tick(); blk_i = 8'hA5;
      tick(); blk_valid_i = 0; rst_ni = 1'b0; #1;
      chk("req19_no_clr", sr_clr_o, 0);
      chk("req19_frame_cnt", frame_cnt_o, 0);
      tick(); rst_ni = 1'b1;
      load_frame(32'h0D0C0B0A); #1;
      chk("req19_fresh_data", sr_data_o, 32'h0D0C0B0A);
      ready_pulse();
      ready_pulse();

      // Frame counter saturation
      @(negedge clk); #1;
      force dut.frame_cnt_reg = 16'hFFFF;
      #1 release dut.frame_cnt_reg;
      sat_req++;
      load_frame(32'h13579BDF);
      ready_pulse(); #1;
      chk("req27_saturated", frame_cnt_o, 16'hFFFF);
      ready_pulse();

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         tick();
         enable_i      = ($urandom % 8) != 0;
         blk_valid_i   = ($urandom % 3) != 0;
         blk_i         = 8'($urandom);
         sr_ready_i    = ($urandom % 10) == 0;
         sr_shift_en_i = 1'($urandom);
         sr_first_hs_i = ($urandom % 12) == 0;
         clr_i         = ($urandom % 50) == 0;
      end
      tick();
      clr_i = 0; enable_i = 0; blk_valid_i = 0; sr_ready_i = 0; sr_shift_en_i = 0; sr_first_hs_i = 0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dequeue_feed_ctrl.md
DEQUEUE_FEED_CTRL -- requirements
Module: dequeue_feed_ctrl

Interface
REQ-001 SHALL have parameter BlockSize, default 8, bits per block including the interleaved start bit.
REQ-002 SHALL have parameter NumBlocks, default 4, blocks per frame loaded into the dequeue shift register.
REQ-003 SHALL have parameter TimeoutCycles, default 64, maximum FEED cycles without a first output handshake.
REQ-004 SHALL have the following ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous flush request
- enable_i  in  1  gates block intake and shifting
- blk_valid_i  in  1  upstream block valid
- blk_ready_o  out  1  upstream block accepted
- blk_i  in  BlockSize  upstream block
- sr_valid_o  out  1  frame valid to the shift register
- sr_ready_i  in  1  shift register ready
- sr_data_o  out  BlockSize*NumBlocks  frame; block 0 in the LSBs
- sr_new_packet_o  out  BlockSize  filler block for shifting
- sr_shift_en_o  out  1  shift permission to the shift register
- sr_shift_en_i  in  1  shift register actually shifts this cycle
- sr_first_hs_i  in  1  first output handshake of the current frame
- sr_clr_o  out  1  synchronous clear to the shift register
- timeout_o  out  1  one-cycle pulse on a timeout flush
- frame_cnt_o  out  16  frames loaded, saturating
- drop_cnt_o  out  16  flushes caused by timeout, saturating

Function
REQ-005 SHALL implement FSM states FILL, OFFER, FEED, FLUSH.
REQ-006 FILL: blk_ready_o=enable_i; each accepted block SHALL be written to frame slot blk_idx, and blk_idx SHALL increment; after slot NumBlocks-1 is written, blk_idx SHALL wrap to 0 and the FSM SHALL go to OFFER next cycle.
REQ-007 OFFER: sr_valid_o=1 and sr_data_o stable until sr_valid_o&sr_ready_i; on that handshake, frame_cnt_o SHALL increment and the FSM SHALL go to FEED.
REQ-008 FEED: sr_shift_en_o=enable_i&blk_valid_i; sr_new_packet_o=blk_i; blk_ready_o=sr_shift_en_i (combinational, no path from blk_ready_o to blk_valid_i).
REQ-009 FEED: when sr_ready_i=1 (frame fully consumed), the FSM SHALL go to FILL with blk_idx=0.
REQ-010 FEED: the timeout counter SHALL clear on FEED entry and on sr_first_hs_i, and increment otherwise; reaching TimeoutCycles-1 SHALL cause a transition to FLUSH.
REQ-011 FLUSH SHALL last exactly one cycle: sr_clr_o=1, blk_ready_o=0, then FILL with blk_idx=0 and the frame buffer cleared.
REQ-012 On a timeout entry to FLUSH, timeout_o SHALL pulse in the FLUSH cycle and drop_cnt_o SHALL increment; a clr_i entry SHALL do neither.
REQ-013 clr_i=1 in any state SHALL force FLUSH next cycle, overriding all other transitions; blocks accepted in the same cycle SHALL be discarded.
REQ-014 sr_valid_o, sr_shift_en_o, and sr_clr_o SHALL be mutually exclusive.
REQ-015 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-016 In FEED with sr_ready_i=1 and timeout expiry in the same cycle, the transition SHALL be to FILL with no timeout pulse.
REQ-017 enable_i=0 SHALL freeze intake and shifting but SHALL NOT stop the timeout counter.

Reset
REQ-018 On rst_ni=0, state=FILL, blk_idx=0, timeout counter=0, frame buffer=0, frame_cnt_o=0, drop_cnt_o=0, and all handshake/pulse outputs=0 except blk_ready_o=enable_i.
REQ-019 Reset mid-frame SHALL discard partial frames with no sr_clr_o pulse.

Structure
REQ-020 Typedef feed_state_e and the 16-bit counter type SHALL reside in serial_link_pkg.
REQ-021 The frame buffer plus blk_idx SHALL be a sub-module dequeue_frame_collector; the FSM and counters SHALL be top-level.

Verification
REQ-022 Feed 4 blocks 0x01,0x03,0x05,0x07 -> sr_data_o=0x07050301 with sr_valid_o held until sr_ready_i; frame_cnt_o=1.
REQ-023 In FEED, blk_valid_i=1 and sr_shift_en_i=1 for 3 cycles -> 3 blocks consumed, blk_ready_o matches sr_shift_en_i each cycle.
REQ-024 TimeoutCycles=8, no sr_first_hs_i in FEED -> FLUSH on the 8th FEED cycle, sr_clr_o and timeout_o pulse for 1 cycle, drop_cnt_o=1.
REQ-025 clr_i during FILL with 2 of 4 blocks stored -> one sr_clr_o cycle, blk_idx=0, next frame assembled from fresh blocks only.
REQ-026 sr_ready_i and timeout expiry in the same cycle -> FILL, timeout_o=0, drop_cnt_o unchanged.
REQ-027 Force frame_cnt_o to 0xFFFF, load one more frame -> value stays 0xFFFF.
